// File: rtl/vending_ctrl_param_if.sv
// Bundles the vending-controller front-end pulses and the display/piezo/LCD outputs.
// The controller connects through the slave modport, its driver through master.
interface vending_ctrl_param_if #(
  parameter int NUM_ITEMS = 8,
  parameter int NUM_COINS = 4,
  parameter int MONEY_W   = 8,
  parameter int STOCK_W   = 4
);
  localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  logic [NUM_ITEMS-1:0]         item_pulse;
  logic [NUM_COINS-1:0]         coin_pulse;
  logic                         refund_pulse;
  logic                         admin_mode;
  logic [MONEY_W-1:0]           credit;
  logic                         vend_valid;
  logic [ITEM_W-1:0]            vend_item;
  logic                         change_valid;
  logic [MONEY_W-1:0]           change_out;
  logic [2:0]                   status;
  logic                         note_valid;
  logic [NUM_ITEMS*STOCK_W-1:0] stock_flat;

  modport slave (
    input  item_pulse, coin_pulse, refund_pulse, admin_mode,
    output credit, vend_valid, vend_item, change_valid, change_out,
           status, note_valid, stock_flat
  );

  modport master (
    output item_pulse, coin_pulse, refund_pulse, admin_mode,
    input  credit, vend_valid, vend_item, change_valid, change_out,
           status, note_valid, stock_flat
  );
endinterface

// File: rtl/vending_ctrl_param.sv
// Vending-machine control core: saturating credit, per-item stock, refund,
// timed error/info messages and an admin restock mode. One event per cycle.
module vending_ctrl_param #(
  parameter int NUM_ITEMS  = 8,
  parameter int NUM_COINS  = 4,
  parameter int MONEY_W    = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter logic [NUM_ITEMS*MONEY_W-1:0] PRICE_LIST =
    {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10},
  parameter logic [NUM_COINS*MONEY_W-1:0] COIN_LIST =
    {8'd50, 8'd10, 8'd5, 8'd1},
  parameter int MSG_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst,
  vending_ctrl_param_if.slave  bus
);
  localparam int ITEM_W  = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int COIN_W  = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int TIMER_W = $clog2(MSG_CYCLES + 1);
  localparam logic [STOCK_W-1:0] INIT_STK  = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] MAX_STOCK = '1;
  localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(MSG_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_MSG    = 2'd2;
  localparam logic [1:0] S_ADMIN  = 2'd3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CREDIT    = 3'd1;
  localparam logic [2:0] ST_VEND      = 3'd2;
  localparam logic [2:0] ST_SOLD_OUT  = 3'd3;
  localparam logic [2:0] ST_NO_CREDIT = 3'd4;
  localparam logic [2:0] ST_REJECT    = 3'd5;
  localparam logic [2:0] ST_ADMIN     = 3'd6;
  localparam logic [2:0] ST_CHANGE    = 3'd7;

  logic [1:0]         state_q, state_d;
  logic               admin_q;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
  logic [2:0]         status_q, status_d;
  logic               vend_valid_q, vend_valid_d;
  logic [ITEM_W-1:0]  vend_item_q, vend_item_d;
  logic               change_valid_q, change_valid_d;
  logic [MONEY_W-1:0] change_out_q, change_out_d;
  logic               note_q, note_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic               item_hit, coin_hit, admin_rise;
  logic [ITEM_W-1:0]  item_idx;
  logic [COIN_W-1:0]  coin_idx;
  logic [MONEY_W-1:0] price, coin_val, remain;
  logic [MONEY_W:0]   coin_sum;

  // Descending scan so the lowest set bit is the last to overwrite the index.
  always_comb begin
    item_hit = 1'b0;
    item_idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (bus.item_pulse[i]) begin
        item_hit = 1'b1;
        item_idx = ITEM_W'(i);
      end
    end
    coin_hit = 1'b0;
    coin_idx = '0;
    for (int j = NUM_COINS - 1; j >= 0; j--) begin
      if (bus.coin_pulse[j]) begin
        coin_hit = 1'b1;
        coin_idx = COIN_W'(j);
      end
    end
  end

  assign price      = PRICE_LIST[item_idx*MONEY_W +: MONEY_W];
  assign coin_val   = COIN_LIST[coin_idx*MONEY_W +: MONEY_W];
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
  assign remain     = credit_q - price;
  assign admin_rise = bus.admin_mode && !admin_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    vend_valid_d   = 1'b0;
    vend_item_d    = vend_item_q;
    change_valid_d = 1'b0;
    change_out_d   = change_out_q;
    note_d         = 1'b0;
    timer_d        = timer_q;
    case (state_q)
      S_IDLE:   status_d = ST_IDLE;
      S_CREDIT: status_d = ST_CREDIT;
      S_ADMIN:  status_d = ST_ADMIN;
      default:  status_d = status_q;
    endcase

    if (admin_rise) begin
      state_d  = S_ADMIN;
      status_d = ST_ADMIN;
      note_d   = 1'b1;
      if (credit_q != '0) begin
        change_valid_d = 1'b1;
        change_out_d   = credit_q;
        credit_d       = '0;
      end
    end else if (state_q == S_ADMIN) begin
      if (!bus.admin_mode) begin
        state_d  = S_IDLE;
        status_d = ST_IDLE;
      end else if (bus.refund_pulse) begin
        for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = INIT_STK;
      end else if (item_hit && stock_q[item_idx] != MAX_STOCK) begin
        stock_d[item_idx] = stock_q[item_idx] + 1'b1;
      end
    end else if (bus.refund_pulse && credit_q != '0) begin
      change_valid_d = 1'b1;
      change_out_d   = credit_q;
      credit_d       = '0;
      state_d        = S_IDLE;
      status_d       = ST_CHANGE;
      note_d         = 1'b1;
    end else if (item_hit) begin
      note_d = 1'b1;
      if (stock_q[item_idx] == '0) begin
        state_d  = S_MSG;
        status_d = ST_SOLD_OUT;
        timer_d  = '0;
      end else if (credit_q < price) begin
        state_d  = S_MSG;
        status_d = ST_NO_CREDIT;
        timer_d  = '0;
      end else begin
        credit_d          = remain;
        stock_d[item_idx] = stock_q[item_idx] - 1'b1;
        vend_valid_d      = 1'b1;
        vend_item_d       = item_idx;
        status_d          = ST_VEND;
        state_d           = (remain != '0) ? S_CREDIT : S_IDLE;
      end
    end else if (coin_hit) begin
      note_d = 1'b1;
      if (!coin_sum[MONEY_W]) begin
        credit_d = coin_sum[MONEY_W-1:0];
        state_d  = S_CREDIT;
        status_d = ST_CREDIT;
      end else begin
        state_d  = S_MSG;
        status_d = ST_REJECT;
        timer_d  = '0;
      end
    end else if (state_q == S_MSG) begin
      if (timer_q == TIMER_END) begin
        state_d  = (credit_q != '0) ? S_CREDIT : S_IDLE;
        status_d = (credit_q != '0) ? ST_CREDIT : ST_IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      admin_q        <= 1'b0;
      credit_q       <= '0;
      status_q       <= ST_IDLE;
      vend_valid_q   <= 1'b0;
      vend_item_q    <= '0;
      change_valid_q <= 1'b0;
      change_out_q   <= '0;
      note_q         <= 1'b0;
      timer_q        <= '0;
      // NOTE: the stock array is a small register file that must come up at
      // INIT_STOCK, so it is reset explicitly rather than left to a RAM.
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= INIT_STK;
    end else begin
      state_q        <= state_d;
      admin_q        <= bus.admin_mode;
      credit_q       <= credit_d;
      status_q       <= status_d;
      vend_valid_q   <= vend_valid_d;
      vend_item_q    <= vend_item_d;
      change_valid_q <= change_valid_d;
      change_out_q   <= change_out_d;
      note_q         <= note_d;
      timer_q        <= timer_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign bus.credit       = credit_q;
  assign bus.vend_valid   = vend_valid_q;
  assign bus.vend_item    = vend_item_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_out   = change_out_q;
  assign bus.status       = status_q;
  assign bus.note_valid   = note_q;

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_stock
    assign bus.stock_flat[g*STOCK_W +: STOCK_W] = stock_q[g];
  end
endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed bench for vending_ctrl_param: inputs change on the falling edge,
// outputs are compared on the following falling edge against hand-worked values.
module tb_vending_ctrl_param;
  localparam int NI = 8;
  localparam int NC = 4;
  localparam int MW = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vending_ctrl_param_if #(.NUM_ITEMS(NI), .NUM_COINS(NC), .MONEY_W(MW), .STOCK_W(SW)) bus ();

  vending_ctrl_param #(
    .NUM_ITEMS(NI), .NUM_COINS(NC), .MONEY_W(MW), .STOCK_W(SW),
    .INIT_STOCK(5), .MSG_CYCLES(1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Coin bit: 0=1, 1=5, 2=10, 3=50. Item i price = 10*(i+1).
  localparam logic [3:0] C5  = 4'b0010;
  localparam logic [3:0] C10 = 4'b0100;
  localparam logic [3:0] C50 = 4'b1000;

  task automatic do_reset();
    rst              = 1'b1;
    bus.item_pulse   = '0;
    bus.coin_pulse   = '0;
    bus.refund_pulse = 1'b0;
    bus.admin_mode   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle pulse; returns on the falling edge after the capturing rising edge.
  task automatic drive(input logic [NI-1:0] item, input logic [NC-1:0] coin, input logic refund);
    @(negedge clk);
    bus.item_pulse   = item;
    bus.coin_pulse   = coin;
    bus.refund_pulse = refund;
    @(negedge clk);
    bus.item_pulse   = '0;
    bus.coin_pulse   = '0;
    bus.refund_pulse = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.credit !== 8'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", bus.credit); end
    checks++; if (bus.status !== 3'd0) begin errors++; $display("FAIL reset_status: got %0d want 0", bus.status); end
    checks++; if ({bus.vend_valid, bus.change_valid, bus.note_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b want 000", {bus.vend_valid, bus.change_valid, bus.note_valid}); end
    checks++; if (bus.stock_flat !== 32'h5555_5555) begin errors++; $display("FAIL reset_stock: got %h want 55555555", bus.stock_flat); end
  endtask

  task automatic test_purchase();
    do_reset();
    drive('0, C10, 1'b0);
    checks++; if (bus.credit !== 8'd10 || bus.status !== 3'd1 || bus.note_valid !== 1'b1) begin
      errors++; $display("FAIL buy_coin1: credit=%0d status=%0d note=%b want 10/1/1", bus.credit, bus.status, bus.note_valid); end
    drive('0, C10, 1'b0);
    checks++; if (bus.credit !== 8'd20) begin errors++; $display("FAIL buy_coin2: got %0d want 20", bus.credit); end
    drive(8'b0000_0010, '0, 1'b0);
    checks++; if (bus.vend_valid !== 1'b1 || bus.vend_item !== 3'd1 || bus.credit !== 8'd0 || bus.status !== 3'd2) begin
      errors++; $display("FAIL buy_vend: vv=%b item=%0d credit=%0d status=%0d want 1/1/0/2",
                         bus.vend_valid, bus.vend_item, bus.credit, bus.status); end
    @(negedge clk);
    checks++; if (bus.vend_valid !== 1'b0 || bus.status !== 3'd0) begin
      errors++; $display("FAIL buy_after: vv=%b status=%0d want 0/0", bus.vend_valid, bus.status); end
    checks++; if (bus.stock_flat !== 32'h5555_5545) begin errors++; $display("FAIL buy_stock: got %h want 55555545", bus.stock_flat); end
  endtask

  task automatic test_refund();
    do_reset();
    drive('0, C50, 1'b0);
    drive(8'b0000_0001, '0, 1'b0);
    checks++; if (bus.vend_valid !== 1'b1 || bus.vend_item !== 3'd0 || bus.credit !== 8'd40) begin
      errors++; $display("FAIL ref_vend: vv=%b item=%0d credit=%0d want 1/0/40", bus.vend_valid, bus.vend_item, bus.credit); end
    drive('0, '0, 1'b1);
    checks++; if (bus.change_valid !== 1'b1 || bus.change_out !== 8'd40 || bus.credit !== 8'd0 || bus.status !== 3'd7) begin
      errors++; $display("FAIL ref_change: cv=%b out=%0d credit=%0d status=%0d want 1/40/0/7",
                         bus.change_valid, bus.change_out, bus.credit, bus.status); end
    @(negedge clk);
    checks++; if (bus.change_valid !== 1'b0 || bus.status !== 3'd0) begin
      errors++; $display("FAIL ref_after: cv=%b status=%0d want 0/0", bus.change_valid, bus.status); end
  endtask

  task automatic test_msg_timeout();
    do_reset();
    drive('0, C5, 1'b0);
    drive(8'b1000_0000, '0, 1'b0);
    checks++; if (bus.status !== 3'd4 || bus.credit !== 8'd5 || bus.note_valid !== 1'b1) begin
      errors++; $display("FAIL msg_nocredit: status=%0d credit=%0d note=%b want 4/5/1", bus.status, bus.credit, bus.note_valid); end
    @(negedge clk);
    checks++; if (bus.note_valid !== 1'b0) begin errors++; $display("FAIL msg_note_one: got %b want 0", bus.note_valid); end
    repeat (998) @(negedge clk);
    checks++; if (bus.status !== 3'd4) begin errors++; $display("FAIL msg_hold_999: got %0d want 4", bus.status); end
    @(negedge clk);
    checks++; if (bus.status !== 3'd1 || bus.note_valid !== 1'b0) begin
      errors++; $display("FAIL msg_timeout: status=%0d note=%b want 1/0", bus.status, bus.note_valid); end
    // Second message aborted halfway by a coin.
    drive(8'b1000_0000, '0, 1'b0);
    checks++; if (bus.status !== 3'd4) begin errors++; $display("FAIL msg2_enter: got %0d want 4", bus.status); end
    repeat (499) @(negedge clk);
    drive('0, C5, 1'b0);
    checks++; if (bus.status !== 3'd1 || bus.credit !== 8'd10 || bus.note_valid !== 1'b1) begin
      errors++; $display("FAIL msg2_abort: status=%0d credit=%0d note=%b want 1/10/1", bus.status, bus.credit, bus.note_valid); end
    repeat (600) @(negedge clk);
    checks++; if (bus.status !== 3'd1 || bus.credit !== 8'd10) begin
      errors++; $display("FAIL msg2_stay: status=%0d credit=%0d want 1/10", bus.status, bus.credit); end
  endtask

  task automatic test_reject();
    do_reset();
    repeat (5) drive('0, C50, 1'b0);
    checks++; if (bus.credit !== 8'd250) begin errors++; $display("FAIL rej_fill: got %0d want 250", bus.credit); end
    drive('0, C10, 1'b0);
    checks++; if (bus.status !== 3'd5 || bus.credit !== 8'd250 || bus.note_valid !== 1'b1) begin
      errors++; $display("FAIL rej_over: status=%0d credit=%0d note=%b want 5/250/1", bus.status, bus.credit, bus.note_valid); end
  endtask

  task automatic test_sold_out();
    do_reset();
    repeat (4) drive('0, C50, 1'b0);
    repeat (5) drive(8'b0000_0100, '0, 1'b0);
    checks++; if (bus.credit !== 8'd50 || bus.stock_flat !== 32'h5555_5055) begin
      errors++; $display("FAIL so_drain: credit=%0d stock=%h want 50/55555055", bus.credit, bus.stock_flat); end
    drive(8'b0000_0100, '0, 1'b0);
    checks++; if (bus.status !== 3'd3 || bus.credit !== 8'd50 || bus.vend_valid !== 1'b0) begin
      errors++; $display("FAIL so_sixth: status=%0d credit=%0d vv=%b want 3/50/0", bus.status, bus.credit, bus.vend_valid); end
    drive(8'b0000_0110, '0, 1'b0);
    checks++; if (bus.vend_valid !== 1'b1 || bus.vend_item !== 3'd1 || bus.credit !== 8'd30 ||
                  bus.stock_flat !== 32'h5555_5045) begin
      errors++; $display("FAIL so_multi: vv=%b item=%0d credit=%0d stock=%h want 1/1/30/55555045",
                         bus.vend_valid, bus.vend_item, bus.credit, bus.stock_flat); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive('0, C50, 1'b0);
    drive(8'b0000_0001, C50, 1'b0);
    checks++; if (bus.vend_valid !== 1'b1 || bus.credit !== 8'd40) begin
      errors++; $display("FAIL prio_item_coin: vv=%b credit=%0d want 1/40", bus.vend_valid, bus.credit); end
    drive(8'b0000_0001, C50, 1'b1);
    checks++; if (bus.change_valid !== 1'b1 || bus.change_out !== 8'd40 || bus.vend_valid !== 1'b0 || bus.credit !== 8'd0) begin
      errors++; $display("FAIL prio_refund: cv=%b out=%0d vv=%b credit=%0d want 1/40/0/0",
                         bus.change_valid, bus.change_out, bus.vend_valid, bus.credit); end
  endtask

  task automatic test_admin();
    do_reset();
    repeat (3) drive('0, C10, 1'b0);
    @(negedge clk);
    bus.admin_mode = 1'b1;
    @(negedge clk);
    checks++; if (bus.change_valid !== 1'b1 || bus.change_out !== 8'd30 || bus.credit !== 8'd0 ||
                  bus.status !== 3'd6 || bus.note_valid !== 1'b1) begin
      errors++; $display("FAIL adm_enter: cv=%b out=%0d credit=%0d status=%0d note=%b want 1/30/0/6/1",
                         bus.change_valid, bus.change_out, bus.credit, bus.status, bus.note_valid); end
    repeat (12) drive(8'b0000_1000, '0, 1'b0);
    checks++; if (bus.stock_flat !== 32'h5555_F555) begin errors++; $display("FAIL adm_sat: got %h want 5555F555", bus.stock_flat); end
    drive('0, C50, 1'b0);
    checks++; if (bus.credit !== 8'd0 || bus.status !== 3'd6) begin
      errors++; $display("FAIL adm_coin: credit=%0d status=%0d want 0/6", bus.credit, bus.status); end
    drive('0, '0, 1'b1);
    checks++; if (bus.stock_flat !== 32'h5555_5555) begin errors++; $display("FAIL adm_restock: got %h want 55555555", bus.stock_flat); end
    @(negedge clk);
    bus.admin_mode = 1'b0;
    @(negedge clk);
    checks++; if (bus.status !== 3'd0) begin errors++; $display("FAIL adm_exit: got %0d want 0", bus.status); end
    bus.admin_mode = 1'b1;
    @(negedge clk);
    checks++; if (bus.status !== 3'd6 || bus.change_valid !== 1'b0) begin
      errors++; $display("FAIL adm_reenter: status=%0d cv=%b want 6/0", bus.status, bus.change_valid); end
    drive(8'b0000_1000, '0, 1'b0);
    checks++; if (bus.stock_flat !== 32'h5555_6555) begin errors++; $display("FAIL adm_inc: got %h want 55556555", bus.stock_flat); end
    // Asynchronous reset between clock edges.
    #2;
    rst            = 1'b1;
    bus.admin_mode = 1'b0;
    #1;
    checks++; if (bus.status !== 3'd0 || bus.credit !== 8'd0 || bus.stock_flat !== 32'h5555_5555 ||
                  bus.note_valid !== 1'b0 || bus.change_valid !== 1'b0) begin
      errors++; $display("FAIL adm_async_rst: status=%0d credit=%0d stock=%h note=%b cv=%b want 0/0/55555555/0/0",
                         bus.status, bus.credit, bus.stock_flat, bus.note_valid, bus.change_valid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_refund();
    test_msg_timeout();
    test_reject();
    test_sold_out();
    test_back_to_back();
    test_admin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
